// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream and writes
// it into instruction memory. The processor core is held in reset until the
// frame has loaded and its checksum matches.
//
// Frame: SYNC_BYTE, LEN (word count N), 4*N payload bytes (little-endian per
// word), CHK (XOR of all payload bytes).
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   rx_valid   in   rx_data holds a valid byte
//   rx_data    in   byte stream
//   rx_ready   out  byte accepted when rx_valid && rx_ready at a clk edge
//   imem_we    out  one-cycle instruction-memory write strobe
//   imem_addr  out  word address of the write
//   imem_wdata out  assembled instruction word
//   core_reset out  holds the core in reset; low only once a load is done
//   done       out  program loaded and checksum good
//   error      out  frame rejected
module imem_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [6:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;
  // Last written address/data, so the memory bus holds its value between writes.
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic accept;
  logic len_ok;

  assign accept = rx_valid && rx_ready;
  assign len_ok = (rx_data != 8'd0) && (32'(rx_data) <= MAX_WORDS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= 8'd0;
      word_cnt_q <= 7'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      chk_q      <= 8'd0;
      addr_q     <= 6'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      chk_q      <= chk_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    chk_d      = chk_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rx_ready   = (state_q != StWrite);
    imem_we    = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept && rx_data == SYNC_BYTE) state_d = StLen;
      end
      StLen: begin
        if (accept) begin
          if (len_ok) begin
            len_d      = rx_data;
            word_cnt_d = 7'd0;
            byte_cnt_d = 2'd0;
            chk_d      = 8'd0;
            state_d    = StData;
          end else begin
            state_d = StErr;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          chk_d      = chk_q ^ rx_data;
          // Wraps to 0 after the 4th byte, ready for the next word.
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        imem_we    = 1'b1;
        addr_d     = word_cnt_q[5:0];
        wdata_d    = word_q;
        word_cnt_d = word_cnt_q + 7'd1;
        state_d    = ({1'b0, word_cnt_d} == len_q) ? StChk : StData;
      end
      StChk: begin
        if (accept) state_d = (rx_data == chk_q) ? StDone : StErr;
      end
      StDone: begin
        done       = 1'b1;
        core_reset = 1'b0;
        if (accept && rx_data == SYNC_BYTE) state_d = StLen;
      end
      StErr: begin
        error = 1'b1;
        if (accept && rx_data == SYNC_BYTE) state_d = StLen;
      end
      default: state_d = StIdle;
    endcase
  end

  // During WRITE the bus shows the live word; otherwise the last written one.
  assign imem_addr  = (state_q == StWrite) ? word_cnt_q[5:0] : addr_q;
  assign imem_wdata = (state_q == StWrite) ? word_q : wdata_q;

endmodule
